alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//  Reservation station and issue scheduler for the single ALU. Holds dispatched ALU-class ops
//  (lui/auipc/jal/jalr/branch/ri/rr) until their operands arrive on the CDBs, then issues one ready op per cycle.
//  Sits between the decoder/dispatch stage and the alu; drives the alu's yes/op/v1/v2/pc/imm/in_rob_id inputs.
// PARAMETERS
//  RS_SIZE  8  number of entries, power of two, >=2
//  IDX_W    3  log2(RS_SIZE)
// PORTS
//  clk_in         in   1       clock
//  rst_in         in   1       synchronous active-high reset
//  rdy_in         in   1       0 = stall: hold all state, alu_yes_out=0
//  clear_in       in   1       mispredict flush
//  disp_valid_in  in   1       dispatch request
//  disp_op_in     in   11      op as the alu expects: [6:0] opcode, [9:7] funct3, [10] funct7 bit
//  disp_pc_in / disp_imm_in   in  32   instruction pc / immediate
//  disp_rob_id_in in   `ROB_R  destination ROB tag
//  disp_q1p_in, disp_q2p_in   in  1    operand 1/2 pending
//  disp_q1_in, disp_q2_in     in  `ROB_R  producer tags when pending
//  disp_v1_in, disp_v2_in     in  32   operand values when not pending
//  full_out       out  1       all entries busy (from registered busy vector)
//  cdb0_valid_in / cdb0_rob_id_in / cdb0_value_in  in  1/`ROB_R/32  ALU result bus
//  cdb1_valid_in / cdb1_rob_id_in / cdb1_value_in  in  1/`ROB_R/32  LSB result bus
//  alu_yes_out    out  1       issue strobe to alu
//  alu_op_out 11, alu_v1_out 32, alu_v2_out 32, alu_pc_out 32, alu_imm_out 32, alu_rob_id_out `ROB_R  out  registered issue payload
// BEHAVIOUR
//  Reset: all busy=0; alu_yes_out=0, all alu_*_out=0; full_out=0.
//  Priority per edge: rst_in > !rdy_in (hold) > clear_in > normal.
//  clear_in: all busy cleared, alu_yes_out=0 next cycle, same-cycle dispatch dropped.
//  Dispatch: accepted iff disp_valid_in && !full_out; written to lowest-index free entry. Dispatch while full
//   ignored (no state change). Decoder clears qNp for unused operands; RS does no decoding.
//  Dispatch-time forwarding: if qNp and a valid CDB tag equals qN in the same cycle, store value, qNp=0.
//  Wakeup: each busy entry with qNp=1 matching a valid CDB tag captures value, clears qNp. Both CDBs may
//   hit the same or different entries/operands in one cycle; both are applied.
//  Ready = busy & !q1p & !q2p, from registered state only (woken in cycle t -> selectable t+1).
//  Issue: at most one ready entry selected per cycle; payload registered, alu_yes_out=1 next cycle;
//   entry busy cleared at the same edge. No ready entry -> alu_yes_out=0 (payload holds).
//  Latency: dispatch in cycle t with both operands ready -> alu_yes_out in t+2. CDB wake in t -> alu_yes_out t+2.
//  Freed slot not reflected in full_out until next cycle; dispatch+issue in same cycle both occur.
// CONFIGURATION
//  RS_AGE_PRIORITY_EN defined: RS_SIZE x RS_SIZE age matrix; on allocate of entry i, mark every currently busy
//   entry older than i; select the oldest ready entry.
//  Undefined: select the lowest-index ready entry; no age matrix.
// STRUCTURE
//  `ROB_R and opcode macros come from const.v; add `RS_SIZE / `RS_IDX_W defaults there.
//  Sub-module rs_select: ready vector (+ age matrix when enabled) -> valid + index. All else in alu_rs.
// TESTING
//  1 Reset 2 cycles -> alu_yes_out=0, full_out=0, alu_rob_id_out=0.
//  2 Dispatch addi op=0x013 v1=5 imm=3 rob=2, both ready, cycle t -> t+2 alu_yes_out=1, v1=5, imm=3, rob=2; t+3 alu_yes_out=0.
//  3 Dispatch add q1p=1 q1=4, v2=7; cdb1 rob4 value 0x10 in t+3 -> alu_yes_out in t+5, v1=0x10, v2=7.
//    Repeat with cdb0 rob4 in the dispatch cycle -> forwarded, issue at t+2.
//  4 Dispatch 8 ops all pending on tag 9 -> full_out=1; 9th dispatch ignored; cdb0 rob9 -> 8 issues on
//    consecutive cycles, full_out=0 the cycle after the first issue.
//  5 Entries busy, pending; clear_in 1 cycle -> full_out=0 next cycle, no alu_yes_out even after cdb matches.
//  6 Entry1=B (older), entry0=C (younger) both woken by one CDB -> macro on: B issues first; off: C first.
//    rdy_in=0 during a wake cycle -> wake deferred, no issue until rdy_in=1.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station.
// Entry layout, issue payload and the CDB snoop helper.
package alu_rs_pkg;

  localparam int RS_DEF  = 8;
  localparam int IDX_DEF = 3;
  localparam int ROB_W   = 4;
  localparam int OP_W    = 11;
  localparam int XLEN    = 32;

  typedef logic [ROB_W-1:0] rob_t;
  typedef logic [OP_W-1:0]  op_t;
  typedef logic [XLEN-1:0]  word_t;

  typedef struct packed {
    op_t   op;
    word_t pc;
    word_t imm;
    rob_t  rob;
    logic  q1p;
    rob_t  q1;
    word_t v1;
    logic  q2p;
    rob_t  q2;
    word_t v2;
  } rs_ent_t;

  typedef struct packed {
    op_t   op;
    word_t v1;
    word_t v2;
    word_t pc;
    word_t imm;
    rob_t  rob;
  } alu_req_t;

  // Capture any pending operand whose producer tag is on a CDB.
  function automatic rs_ent_t snoop(
    input rs_ent_t e,
    input logic    c0v,
    input rob_t    c0t,
    input word_t   c0d,
    input logic    c1v,
    input rob_t    c1t,
    input word_t   c1d
  );
    rs_ent_t r;
    r = e;
    if (r.q1p && c0v && r.q1 == c0t) begin
      r.v1  = c0d;
      r.q1p = 1'b0;
    end else if (r.q1p && c1v && r.q1 == c1t) begin
      r.v1  = c1d;
      r.q1p = 1'b0;
    end
    if (r.q2p && c0v && r.q2 == c0t) begin
      r.v2  = c0d;
      r.q2p = 1'b0;
    end else if (r.q2p && c1v && r.q2 == c1t) begin
      r.v2  = c1d;
      r.q2p = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, CDB and ALU-issue bundle of the ALU RS.
// master = dispatch/CDB side, slave = the RS.
interface alu_rs_if;
  import alu_rs_pkg::*;

  logic  rdy_in;
  logic  clear_in;
  logic  disp_valid_in;
  op_t   disp_op_in;
  word_t disp_pc_in;
  word_t disp_imm_in;
  rob_t  disp_rob_id_in;
  logic  disp_q1p_in;
  logic  disp_q2p_in;
  rob_t  disp_q1_in;
  rob_t  disp_q2_in;
  word_t disp_v1_in;
  word_t disp_v2_in;
  logic  full_out;
  logic  cdb0_valid_in;
  rob_t  cdb0_rob_id_in;
  word_t cdb0_value_in;
  logic  cdb1_valid_in;
  rob_t  cdb1_rob_id_in;
  word_t cdb1_value_in;
  logic  alu_yes_out;
  op_t   alu_op_out;
  word_t alu_v1_out;
  word_t alu_v2_out;
  word_t alu_pc_out;
  word_t alu_imm_out;
  rob_t  alu_rob_id_out;

  modport master (
    output rdy_in, clear_in, disp_valid_in,
    output disp_op_in, disp_pc_in, disp_imm_in,
    output disp_rob_id_in,
    output disp_q1p_in, disp_q2p_in,
    output disp_q1_in, disp_q2_in,
    output disp_v1_in, disp_v2_in,
    output cdb0_valid_in, cdb0_rob_id_in,
    output cdb0_value_in,
    output cdb1_valid_in, cdb1_rob_id_in,
    output cdb1_value_in,
    input  full_out, alu_yes_out, alu_op_out,
    input  alu_v1_out, alu_v2_out, alu_pc_out,
    input  alu_imm_out, alu_rob_id_out
  );

  modport slave (
    input  rdy_in, clear_in, disp_valid_in,
    input  disp_op_in, disp_pc_in, disp_imm_in,
    input  disp_rob_id_in,
    input  disp_q1p_in, disp_q2p_in,
    input  disp_q1_in, disp_q2_in,
    input  disp_v1_in, disp_v2_in,
    input  cdb0_valid_in, cdb0_rob_id_in,
    input  cdb0_value_in,
    input  cdb1_valid_in, cdb1_rob_id_in,
    input  cdb1_value_in,
    output full_out, alu_yes_out, alu_op_out,
    output alu_v1_out, alu_v2_out, alu_pc_out,
    output alu_imm_out, alu_rob_id_out
  );

endinterface

// File: rtl/alu_rs_select.sv
// Issue picker: ready vector -> one entry index.
// RS_AGE_PRIORITY_EN picks the oldest ready entry, else lowest index.
module alu_rs_select #(
  parameter int N = 8,
  parameter int W = 3
) (
`ifdef RS_AGE_PRIORITY_EN
  input  logic [N-1:0][N-1:0] age,
`endif
  input  logic [N-1:0]        ready,
  output logic                valid,
  output logic [W-1:0]        idx
);

  logic [N-1:0] cand;

  // Narrow to candidates, then take the lowest-index one.
  always_comb begin
    cand  = ready;
    valid = 1'b0;
    idx   = '0;
`ifdef RS_AGE_PRIORITY_EN
    for (int i = 0; i < N; i++)
      cand[i] = ready[i] & ~|(age[i] & ready);
`endif
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station / issue scheduler for the ALU.
// Optional RS_AGE_PRIORITY_EN: oldest-ready issue via age matrix.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_DEF,
  parameter int IDX_W   = IDX_DEF
) (
  input logic     clk_in,
  input logic     rst_in,
  alu_rs_if.slave bus
);

  logic [RS_SIZE-1:0] busy;
  rs_ent_t            ent [RS_SIZE];
  rs_ent_t            wk  [RS_SIZE];
  rs_ent_t            nent;
  alu_req_t           req;
  logic               yes;
  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               full;
  logic               accept;

  assign full   = &busy;
  assign accept = bus.disp_valid_in & ~full;

  assign bus.full_out       = full;
  assign bus.alu_yes_out    = yes;
  assign bus.alu_op_out     = req.op;
  assign bus.alu_v1_out     = req.v1;
  assign bus.alu_v2_out     = req.v2;
  assign bus.alu_pc_out     = req.pc;
  assign bus.alu_imm_out    = req.imm;
  assign bus.alu_rob_id_out = req.rob;

  // Ready flags and lowest free slot from registered state.
  always_comb begin
    ready    = '0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready[i] = busy[i] & ~ent[i].q1p & ~ent[i].q2p;
      if (!busy[i])
        free_idx = IDX_W'(i);
    end
  end

  // Next entry contents: CDB wakeup and forwarded dispatch.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      wk[i] = busy[i] ? snoop(ent[i],
        bus.cdb0_valid_in, bus.cdb0_rob_id_in,
        bus.cdb0_value_in,
        bus.cdb1_valid_in, bus.cdb1_rob_id_in,
        bus.cdb1_value_in) : ent[i];
    nent.op  = bus.disp_op_in;
    nent.pc  = bus.disp_pc_in;
    nent.imm = bus.disp_imm_in;
    nent.rob = bus.disp_rob_id_in;
    nent.q1p = bus.disp_q1p_in;
    nent.q1  = bus.disp_q1_in;
    nent.v1  = bus.disp_v1_in;
    nent.q2p = bus.disp_q2p_in;
    nent.q2  = bus.disp_q2_in;
    nent.v2  = bus.disp_v2_in;
    nent = snoop(nent,
      bus.cdb0_valid_in, bus.cdb0_rob_id_in,
      bus.cdb0_value_in,
      bus.cdb1_valid_in, bus.cdb1_rob_id_in,
      bus.cdb1_value_in);
  end

`ifdef RS_AGE_PRIORITY_EN
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age;

  // New entry is younger than everything busy now.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      age <= '0;
    end else if (bus.rdy_in && !bus.clear_in
                 && accept) begin
      age[free_idx] <= busy;
      for (int j = 0; j < RS_SIZE; j++)
        age[j][free_idx] <= 1'b0;
    end
  end

  alu_rs_select #(.N(RS_SIZE), .W(IDX_W)) u_sel (
    .age   (age),
    .ready (ready),
    .valid (sel_valid),
    .idx   (sel_idx)
  );
`else
  alu_rs_select #(.N(RS_SIZE), .W(IDX_W)) u_sel (
    .ready (ready),
    .valid (sel_valid),
    .idx   (sel_idx)
  );
`endif

  // Entry state, issue payload and issue strobe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= '0;
      yes  <= 1'b0;
      req  <= '0;
      for (int i = 0; i < RS_SIZE; i++)
        ent[i] <= '0;
    end else if (!bus.rdy_in) begin
      yes <= 1'b0;
    end else if (bus.clear_in) begin
      busy <= '0;
      yes  <= 1'b0;
    end else begin
      yes <= sel_valid;
      if (sel_valid) begin
        req.op        <= ent[sel_idx].op;
        req.v1        <= ent[sel_idx].v1;
        req.v2        <= ent[sel_idx].v2;
        req.pc        <= ent[sel_idx].pc;
        req.imm       <= ent[sel_idx].imm;
        req.rob       <= ent[sel_idx].rob;
        busy[sel_idx] <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++)
        ent[i] <= wk[i];
      if (accept) begin
        ent[free_idx]  <= nent;
        busy[free_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs.
// Reference model keeps entries with dispatch sequence numbers.
module tb_alu_rs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   run = 1'b0;
  int   tests = 0;
  int   errs  = 0;

  always #5 clk = ~clk;

  alu_rs_if b ();

  alu_rs dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (b)
  );

  typedef struct {
    bit          busy;
    logic [10:0] op;
    logic [31:0] pc, imm, v1, v2;
    logic [3:0]  rob, q1, q2;
    bit          p1, p2;
    int          seq;
  } ment_t;

  ment_t       m [8];
  int          seqc;
  bit          m_yes;
  logic [10:0] m_op;
  logic [31:0] m_v1, m_v2, m_pc, m_imm;
  logic [3:0]  m_rob;
  int          pick, fr, cnt;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               name, got, exp, $time);
    end
  endtask

  // Reference: slots, oldest = smallest seq number.
  always @(posedge clk) begin
    if (rst) begin
      foreach (m[i]) m[i].busy = 0;
      seqc = 0; m_yes = 0; m_op = 0; m_v1 = 0;
      m_v2 = 0; m_pc = 0; m_imm = 0; m_rob = 0;
    end else if (!b.rdy_in) begin
      m_yes = 0;
    end else if (b.clear_in) begin
      foreach (m[i]) m[i].busy = 0;
      m_yes = 0;
    end else begin
      pick = -1; fr = -1; cnt = 0;
      for (int i = 0; i < 8; i++) begin
        if (m[i].busy) cnt++;
        else if (fr < 0) fr = i;
        if (m[i].busy && !m[i].p1 && !m[i].p2) begin
`ifdef RS_AGE_PRIORITY_EN
          if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
          if (pick < 0) pick = i;
`endif
        end
      end
      m_yes = (pick >= 0);
      if (pick >= 0) begin
        m_op = m[pick].op; m_v1 = m[pick].v1;
        m_v2 = m[pick].v2; m_pc = m[pick].pc;
        m_imm = m[pick].imm; m_rob = m[pick].rob;
        m[pick].busy = 0;
      end
      for (int i = 0; i < 8; i++) begin
        if (m[i].busy) begin
          if (m[i].p1 && b.cdb0_valid_in && m[i].q1 == b.cdb0_rob_id_in)
            begin m[i].v1 = b.cdb0_value_in; m[i].p1 = 0; end
          if (m[i].p1 && b.cdb1_valid_in && m[i].q1 == b.cdb1_rob_id_in)
            begin m[i].v1 = b.cdb1_value_in; m[i].p1 = 0; end
          if (m[i].p2 && b.cdb0_valid_in && m[i].q2 == b.cdb0_rob_id_in)
            begin m[i].v2 = b.cdb0_value_in; m[i].p2 = 0; end
          if (m[i].p2 && b.cdb1_valid_in && m[i].q2 == b.cdb1_rob_id_in)
            begin m[i].v2 = b.cdb1_value_in; m[i].p2 = 0; end
        end
      end
      if (b.disp_valid_in && cnt < 8) begin
        m[fr].busy = 1; m[fr].op = b.disp_op_in;
        m[fr].pc = b.disp_pc_in; m[fr].imm = b.disp_imm_in;
        m[fr].rob = b.disp_rob_id_in;
        m[fr].p1 = b.disp_q1p_in; m[fr].q1 = b.disp_q1_in;
        m[fr].v1 = b.disp_v1_in;
        m[fr].p2 = b.disp_q2p_in; m[fr].q2 = b.disp_q2_in;
        m[fr].v2 = b.disp_v2_in;
        if (m[fr].p1 && b.cdb0_valid_in && m[fr].q1 == b.cdb0_rob_id_in)
          begin m[fr].v1 = b.cdb0_value_in; m[fr].p1 = 0; end
        if (m[fr].p1 && b.cdb1_valid_in && m[fr].q1 == b.cdb1_rob_id_in)
          begin m[fr].v1 = b.cdb1_value_in; m[fr].p1 = 0; end
        if (m[fr].p2 && b.cdb0_valid_in && m[fr].q2 == b.cdb0_rob_id_in)
          begin m[fr].v2 = b.cdb0_value_in; m[fr].p2 = 0; end
        if (m[fr].p2 && b.cdb1_valid_in && m[fr].q2 == b.cdb1_rob_id_in)
          begin m[fr].v2 = b.cdb1_value_in; m[fr].p2 = 0; end
        m[fr].seq = seqc; seqc++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run) begin
      cnt = 0;
      foreach (m[i]) if (m[i].busy) cnt++;
      chk("cmp_yes", b.alu_yes_out, m_yes);
      chk("cmp_full", b.full_out, cnt == 8);
      if (m_yes) begin
        chk("cmp_op", b.alu_op_out, m_op);
        chk("cmp_v1", b.alu_v1_out, m_v1);
        chk("cmp_v2", b.alu_v2_out, m_v2);
        chk("cmp_pc", b.alu_pc_out, m_pc);
        chk("cmp_imm", b.alu_imm_out, m_imm);
        chk("cmp_rob", b.alu_rob_id_out, m_rob);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b.rdy_in = 1; b.clear_in = 0; b.disp_valid_in = 0;
    b.cdb0_valid_in = 0; b.cdb1_valid_in = 0;
  endtask

  task automatic disp(input logic [10:0] op, input logic [3:0] rob,
                      input bit p1, input logic [3:0] q1,
                      input logic [31:0] v1,
                      input bit p2, input logic [3:0] q2,
                      input logic [31:0] v2,
                      input logic [31:0] imm);
    b.disp_valid_in = 1; b.disp_op_in = op;
    b.disp_pc_in = 32'h1000 + {rob, 4'h0};
    b.disp_imm_in = imm; b.disp_rob_id_in = rob;
    b.disp_q1p_in = p1; b.disp_q1_in = q1; b.disp_v1_in = v1;
    b.disp_q2p_in = p2; b.disp_q2_in = q2; b.disp_v2_in = v2;
  endtask

  task automatic cdb0(input logic [3:0] t, input logic [31:0] d);
    b.cdb0_valid_in = 1; b.cdb0_rob_id_in = t; b.cdb0_value_in = d;
  endtask

  task automatic cdb1(input logic [3:0] t, input logic [31:0] d);
    b.cdb1_valid_in = 1; b.cdb1_rob_id_in = t; b.cdb1_value_in = d;
  endtask

  logic [3:0] first_rob, second_rob;

  initial begin
    idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    b.disp_valid_in = 0;
    cdb0(0, 0); cdb1(0, 0);
    idle();
    // reset
    repeat (2) tick();
    chk("rst_yes", b.alu_yes_out, 0);
    chk("rst_full", b.full_out, 0);
    chk("rst_rob", b.alu_rob_id_out, 0);
    chk("rst_v1", b.alu_v1_out, 0);
    rst = 0;
    run = 1;
    tick();

    // addi, both ready: issue two cycles later
    disp(11'h013, 2, 0, 0, 5, 0, 0, 0, 3);
    tick(); idle();
    tick();
    chk("addi_yes", b.alu_yes_out, 1);
    chk("addi_op", b.alu_op_out, 32'h013);
    chk("addi_v1", b.alu_v1_out, 5);
    chk("addi_imm", b.alu_imm_out, 3);
    chk("addi_rob", b.alu_rob_id_out, 2);
    tick();
    chk("addi_done", b.alu_yes_out, 0);

    // add waiting on tag 4 via cdb1
    disp(11'h033, 3, 1, 4, 0, 0, 0, 7, 0);
    tick(); idle();
    tick();
    tick(); cdb1(4, 32'h10);
    tick(); idle();
    chk("wake_early", b.alu_yes_out, 0);
    tick();
    chk("wake_yes", b.alu_yes_out, 1);
    chk("wake_v1", b.alu_v1_out, 32'h10);
    chk("wake_v2", b.alu_v2_out, 7);
    chk("wake_rob", b.alu_rob_id_out, 3);
    tick();

    // dispatch-time forwarding from cdb0
    disp(11'h033, 5, 1, 4, 0, 0, 0, 7, 0);
    cdb0(4, 32'h22);
    tick(); idle();
    tick();
    chk("fwd_yes", b.alu_yes_out, 1);
    chk("fwd_v1", b.alu_v1_out, 32'h22);
    chk("fwd_rob", b.alu_rob_id_out, 5);
    tick();

    // fill all 8 on tag 9, 9th ignored, then drain
    for (int k = 0; k < 8; k++) begin
      disp(11'h033, 4'(k), 1, 9, 0, 0, 0, k, 0);
      tick();
    end
    chk("fill_full", b.full_out, 1);
    disp(11'h033, 15, 1, 9, 0, 0, 0, 99, 0);
    tick(); idle();
    chk("fill_full2", b.full_out, 1);
    cdb0(9, 32'h55);
    tick(); idle();
    chk("fill_noiss", b.alu_yes_out, 0);
    chk("fill_full3", b.full_out, 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("drain_yes", b.alu_yes_out, 1);
      chk("drain_rob", b.alu_rob_id_out, k);
      chk("drain_v1", b.alu_v1_out, 32'h55);
      if (k == 0) chk("drain_full", b.full_out, 0);
      tick();
    end
    chk("drain_end", b.alu_yes_out, 0);
    chk("drain_empty", b.full_out, 0);

    // flush with full RS, same-cycle dispatch dropped
    for (int k = 0; k < 8; k++) begin
      disp(11'h033, 4'(k), 1, 6, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    chk("clr_full", b.full_out, 1);
    disp(11'h013, 1, 0, 0, 1, 0, 0, 0, 0);
    b.clear_in = 1;
    tick(); idle();
    chk("clr_empty", b.full_out, 0);
    cdb0(6, 32'h66);
    tick(); idle();
    for (int k = 0; k < 4; k++) begin
      chk("clr_noiss", b.alu_yes_out, 0);
      tick();
    end

    // age order and stall during wake
    disp(11'h033, 1, 1, 12, 0, 0, 0, 0, 0);
    tick();
    disp(11'h033, 2, 1, 10, 0, 0, 0, 0, 0);
    cdb1(12, 32'h77);
    tick(); idle();
    tick();
    chk("age_a_yes", b.alu_yes_out, 1);
    chk("age_a_rob", b.alu_rob_id_out, 1);
    chk("age_a_v1", b.alu_v1_out, 32'h77);
    disp(11'h033, 3, 1, 10, 0, 0, 0, 0, 0);
    tick(); idle();
    b.rdy_in = 0;
    cdb0(10, 32'h88);
    tick(); idle();
    chk("stall_noiss", b.alu_yes_out, 0);
    tick();
    chk("stall_nowake", b.alu_yes_out, 0);
    cdb0(10, 32'h88);
    tick(); idle();
    chk("age_wait", b.alu_yes_out, 0);
    tick();
`ifdef RS_AGE_PRIORITY_EN
    first_rob = 2; second_rob = 3;
`else
    first_rob = 3; second_rob = 2;
`endif
    chk("age_1st_yes", b.alu_yes_out, 1);
    chk("age_1st_rob", b.alu_rob_id_out, first_rob);
    chk("age_1st_v1", b.alu_v1_out, 32'h88);
    tick();
    chk("age_2nd_yes", b.alu_yes_out, 1);
    chk("age_2nd_rob", b.alu_rob_id_out, second_rob);
    tick();
    chk("age_end", b.alu_yes_out, 0);
    chk("age_empty", b.full_out, 0);
    tick();

    run = 0;
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
